// File: rtl/gf2_mac_stage_pkg.sv
// Shared encoder definitions: FSM state type, default code dimensions and
// the GF(2) row-multiply helper used by the parity datapath.
package gf2_mac_stage_pkg;

  localparam int ENC_W = 8;
  localparam int ENC_K = 16;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // A GF(2) product of one message bit with a generator row is a lane-wise AND.
  function automatic logic [ENC_W-1:0] gf2_mul_row(input logic s,
                                                   input logic [ENC_W-1:0] f);
    return {ENC_W{s}} & f;
  endfunction

endpackage

// File: rtl/gf2_mac_stage_row_mul.sv
// Combinational W-lane GF(2) multiply of one message bit by a generator row;
// the W-wide generalisation of the single-bit w = s AND f stage.
module gf2_row_mul #(
  parameter int W = 8
) (
  input  logic         s,
  input  logic [W-1:0] f,
  output logic [W-1:0] w
);

  assign w = {W{s}} & f;

endmodule

// File: rtl/gf2_mac_stage.sv
// Sequential GF(2) multiply-accumulate: XOR-folds K masked generator rows into
// a W-bit parity word and hands it off on a registered valid/ready output.
module gf2_mac_stage
  import gf2_mac_stage_pkg::*;
#(
  parameter int W = ENC_W,
  parameter int K = ENC_K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         s,
  input  logic [W-1:0] f,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] p,
  output logic         busy
);

  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   acc;
  logic [W-1:0]   prod;
  logic [CW-1:0]  cnt;
  logic           acc_in;
  logic           acc_out;
  logic           last_beat;

  gf2_row_mul #(.W(W)) u_row_mul (
    .s (s),
    .f (f),
    .w (prod)
  );

  // Handshake outputs decode the state register only, so no ready-to-ready path.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign busy      = (cnt != '0) || (state == OUT);

  assign acc_in    = in_valid & in_ready;
  assign acc_out   = out_valid & out_ready;
  assign last_beat = acc_in && !clr && (cnt == LAST);

  always_comb begin
    state_nx = state;
    case (state)
      ACC: if (last_beat) state_nx = OUT;
      OUT: if (acc_out)   state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      state <= state_nx;
      if (state == ACC) begin
        // clr wins over a coincident beat, including the last one.
        if (clr) begin
          acc <= '0;
          cnt <= '0;
        end else if (acc_in) begin
          if (cnt == LAST) begin
            p   <= acc ^ prod;
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= acc ^ prod;
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gf2_mac_stage.sv
// Directed and randomized bench for gf2_mac_stage (W=8, K=4) against a
// transaction-level parity model built from a queue of accepted beats.
module tb_gf2_mac_stage;

  localparam int W = 8;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         s = 1'b0;
  logic [W-1:0] f = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] p;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: products of accepted beats for the open codeword.
  logic [W-1:0] beats[$];
  logic         m_out = 1'b0;
  logic [W-1:0] m_p   = '0;

  // Handoffs seen on the DUT's output port: cycle number and word.
  int           hs[$];
  logic [W-1:0] hp[$];

  gf2_mac_stage #(.W(W), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fold_parity();
    logic [W-1:0] x = '0;
    foreach (beats[i]) x ^= beats[i];
    return x;
  endfunction

  // One clock: advance the model from pre-edge inputs, then compare all outputs.
  task automatic tick();
    logic         r_rst = rst;
    logic         r_clr = clr;
    logic         r_iv  = in_valid;
    logic         r_s   = s;
    logic [W-1:0] r_f   = f;
    logic         r_or  = out_ready;
    if (out_valid === 1'b1 && r_or) begin
      hs.push_back(cyc);
      hp.push_back(p);
    end
    @(posedge clk);
    cyc++;
    if (r_rst) begin
      beats.delete();
      m_out = 1'b0;
      m_p   = '0;
    end else if (m_out) begin
      if (r_or) m_out = 1'b0;
    end else if (r_clr) begin
      beats.delete();
    end else if (r_iv) begin
      beats.push_back(r_s ? r_f : '0);
      if (beats.size() == K) begin
        m_p   = fold_parity();
        m_out = 1'b1;
        beats.delete();
      end
    end
    #1;
    chk("in_ready",  W'(in_ready),  W'(!m_out));
    chk("out_valid", W'(out_valid), W'(m_out));
    chk("p",         p,             m_p);
    chk("busy",      W'(busy),      W'(m_out || beats.size() != 0));
  endtask

  task automatic beat(input logic bs, input logic [W-1:0] bf);
    in_valid = 1'b1;
    s = bs;
    f = bf;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int idx;
    logic [W-1:0] row;

    // Reset state
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_p",         p,             8'h00);
    chk("rst_busy",      W'(busy),      W'(0));
    rst = 1'b0;
    tick();

    // Basic accumulate
    beat(1'b1, 8'h0F);
    beat(1'b1, 8'hF0);
    beat(1'b0, 8'hFF);
    beat(1'b1, 8'h01);
    chk("basic_ov", W'(out_valid), W'(1));
    chk("basic_p",  p,             8'hFE);
    tick();
    chk("basic_ir_after", W'(in_ready), W'(1));
    chk("basic_ov_after", W'(out_valid), W'(0));

    // Output backpressure with a beat offered during the stall
    out_ready = 1'b0;
    beat(1'b1, 8'h0F);
    beat(1'b1, 8'hF0);
    beat(1'b0, 8'hFF);
    beat(1'b1, 8'h01);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      s = 1'b1;
      f = 8'hFF;
      tick();
      chk("stall_p",  p,             8'hFE);
      chk("stall_ov", W'(out_valid), W'(1));
      chk("stall_ir", W'(in_ready),  W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    hs.delete();
    hp.delete();
    tick();
    chk("stall_handoffs", W'(hs.size()), W'(1));
    chk("stall_not_consumed", W'(busy), W'(0));
    chk("stall_back_acc", W'(in_ready), W'(1));

    // Back-to-back codewords with continuous valid
    hs.delete();
    hp.delete();
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && hs.size() < 2; c++) begin
      row = 8'h01 << (idx % 4);
      s = 1'b1;
      f = row;
      if (idx >= 8) in_valid = 1'b0;
      if (in_ready === 1'b1 && in_valid) begin
        tick();
        idx++;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", W'(hs.size()), W'(2));
    if (hs.size() == 2) begin
      chk("b2b_p0",     hp[0],              8'h0F);
      chk("b2b_p1",     hp[1],              8'h0F);
      chk("b2b_period", W'(hs[1] - hs[0]),  W'(5));
    end

    // Mid-codeword clr
    beat(1'b1, 8'hAA);
    beat(1'b1, 8'hAA);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", W'(busy), W'(0));
    beat(1'b1, 8'h55);
    beat(1'b0, 8'h00);
    beat(1'b0, 8'h00);
    beat(1'b0, 8'h00);
    chk("clr_ov", W'(out_valid), W'(1));
    chk("clr_p",  p,             8'h55);
    tick();

    // clr coincident with the last beat
    beat(1'b1, 8'h01);
    beat(1'b1, 8'h02);
    beat(1'b1, 8'h04);
    clr = 1'b1;
    beat(1'b1, 8'h08);
    clr = 1'b0;
    chk("clrlast_ov",   W'(out_valid), W'(0));
    chk("clrlast_busy", W'(busy),      W'(0));
    beat(1'b1, 8'h01);
    beat(1'b1, 8'h02);
    beat(1'b1, 8'h04);
    beat(1'b1, 8'h08);
    chk("clrlast_p", p, 8'h0F);
    tick();

    // Reset while holding a finished word
    out_ready = 1'b0;
    beat(1'b1, 8'h12);
    beat(1'b1, 8'h34);
    beat(1'b1, 8'h56);
    beat(1'b1, 8'h78);
    tick();
    chk("rstmid_pre_ov", W'(out_valid), W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_ov", W'(out_valid), W'(0));
    chk("rstmid_ir", W'(in_ready),  W'(1));
    chk("rstmid_p",  p,             8'h00);
    beat(1'b1, 8'h03);
    beat(1'b1, 8'h0C);
    beat(1'b1, 8'h30);
    beat(1'b1, 8'hC0);
    chk("rstmid_new_p", p, 8'hFF);
    out_ready = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      s         = 1'($urandom);
      f         = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gf2_mac_stage.md
Name: gf2_mac_stage

Overview:
- Parametrised, sequential successor to the single-bit GF(2) multiply stage (w = s AND f) used in the encoder datapath.
- Per accepted beat: multiplies one message bit s by a W-bit generator row f (bitwise AND) and XOR-accumulates the product into a W-bit parity register.
- After K beats it presents the finished parity word on a valid/ready output, then re-arms for the next codeword.
- Sits between the message serialiser and the parity/codeword assembler.

Parameters:
- W, 8, parity width in bits; width of f, the accumulator and p.
- K, 16, message bits per codeword, i.e. beats per accumulation; K >= 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  synchronous abort: discard the partial accumulation and restart the codeword.
- in_valid  in  1  s/f beat valid.
- in_ready  out  1  stage can accept a beat.
- s  in  1  message bit.
- f  in  W  generator row matching s.
- out_valid  out  1  parity word p valid.
- out_ready  in  1  downstream accepts p.
- p  out  W  finished parity word.
- busy  out  1  high when the accumulation is part-way (cnt != 0) or the stage is in OUT.

Behaviour:
- Reset (rst=1 at an edge) forces: state=ACC, acc=0, cnt=0, p=0, out_valid=0, in_ready=1, busy=0. rst overrides clr and all handshakes.
- Beat accept: acc_in = in_valid & in_ready.
- Output accept: acc_out = out_valid & out_ready.
- State ACC:
  - in_ready=1, out_valid=0.
  - On acc_in with cnt<K-1: acc <= acc ^ ({W{s}} & f); cnt <= cnt+1.
  - On acc_in with cnt==K-1 (last beat): p <= acc ^ ({W{s}} & f); acc <= 0; cnt <= 0; state <= OUT.
  - A beat with s=0 still counts and leaves acc unchanged.
- State OUT:
  - in_ready=0, out_valid=1, p held stable.
  - On acc_out: state <= ACC, out_valid drops the next cycle, in_ready rises the next cycle.
  - If out_ready is held low, the stage holds indefinitely with p stable. No beat is accepted in OUT; upstream must hold its beat under valid/ready rules.
- Latency and throughput:
  - The last accepted beat produces out_valid=1 on the following cycle.
  - Minimum codeword period is K+1 cycles: K beats plus one OUT cycle with out_ready=1.
- p keeps its last value after handoff until the next codeword completes. Downstream must qualify p with out_valid.
- clr:
  - In ACC: acc <= 0 and cnt <= 0. Any beat accepted in the same cycle is discarded, including a last beat, so no OUT results.
  - In OUT: no effect; the completed word is still delivered.
- Counter is $clog2(K) bits wide; cnt never exceeds K-1 and wraps only through the last-beat path.
- Arithmetic is pure GF(2): AND for the product, XOR for the sum. No carries, no width growth.
- in_ready is a registered state decode with no combinational path from out_ready. out_valid is likewise a registered state decode.

Decomposition:
- Shared encoder package holds:
  - state enum {ACC, OUT}
  - function gf2_mul_row(s, f) returning {W{s}} & f
  - default constants ENC_W, ENC_K
- One natural sub-module: gf2_row_mul (combinational W-lane AND). It is the parametrised generalisation of the single-bit multiply stage.
- Counter, accumulator and FSM stay in gf2_mac_stage.

Test Plan:
- Basic accumulate (W=8, K=4), rst pulse, then beats s,f = (1,8'h0F), (1,8'hF0), (0,8'hFF), (1,8'h01) with out_ready=1:
  - out_valid=1 exactly one cycle after the 4th beat.
  - p=8'hFE; in_ready=1 again the cycle after.
- Output backpressure: same stream with out_ready=0 for 5 cycles:
  - p stays 8'hFE, out_valid=1, in_ready=0 throughout.
  - A beat offered during the stall is not consumed.
  - Release out_ready: one handoff, then ACC.
- Back-to-back codewords, continuous valid and out_ready=1, two codewords (all s=1, f=8'h01, 8'h02, 8'h04, 8'h08, repeated):
  - Two results, p=8'h0F each.
  - Period 5 cycles; second result has no carry-over from the first.
- Mid-codeword clr: 2 beats (1,8'hAA), clr pulse, then 4 beats (1,8'h55), (0,8'h00), (0,8'h00), (0,8'h00):
  - p=8'h55; busy=0 the cycle after clr.
- clr coincident with the last beat:
  - No out_valid; next K beats (1,8'h01), (1,8'h02), (1,8'h04), (1,8'h08) give p=8'h0F.
- Reset mid-operation:
  - rst asserted while in OUT (out_ready=0) clears to out_valid=0, in_ready=1, p=0.
  - Next full codeword (1,8'h03), (1,8'h0C), (1,8'h30), (1,8'hC0) produces p=8'hFF with no stale data.
